uart_word_rx: RTL and testbench

Packs the byte stream from the UART receiver (8-bit data plus a one-cycle enable per byte) into 32-bit little-endian words. Completed words are buffered in a first-word-fall-through FIFO and presented on a valid/ready interface to the host-side logic, for example the DRAM command/test controller. A partial word is discarded after an inter-byte idle timeout, and FIFO overflow is flagged.

---
 rtl/uart_word_rx.sv | 145 ++++++++++++++
 tb/tb_uart_word_rx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_rx.sv
// uart_word_rx
// Packs bytes from a UART receiver into 32-bit little-endian words and buffers
// them in a first-word-fall-through FIFO.
//
// Ports:
//   clk         single clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_data/i_en received byte and its one-cycle strobe
//   o_data      head-of-FIFO word (valid while o_valid=1)
//   o_valid     FIFO not empty
//   i_ready     consumer accepts the head word when o_valid && i_ready
//   o_count     words currently held, 0..DEPTH
//   o_overflow  sticky: a completed word was dropped because the FIFO was full
//   o_drop      one-cycle pulse: a partial word was discarded after idling
//
// Handshake: a word transfers on a rising edge where o_valid=1 and i_ready=1;
// o_data is stable while o_valid=1 and i_ready=0.
module uart_word_rx #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 4000
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic [7:0]               i_data,
  input  logic                     i_en,
  output logic [31:0]              o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Keep the idle counter at least one bit wide even when the timeout is off.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The drop fires on the edge where the counter would step onto TIMEOUT.
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]    idx_q, idx_d;
  logic [23:0]   part_q, part_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          drop_q, drop_d;

  logic [31:0]   mem [DEPTH];

  logic          word_done;
  logic          pop;
  logic          push;
  logic          full;

  assign o_valid    = (count_q != '0);
  assign full       = (count_q == CW'(DEPTH));
  assign pop        = o_valid && i_ready;
  assign word_done  = i_en && (idx_q == 2'd3);
  // A simultaneous pop frees the slot the new word needs, even when full.
  assign push       = word_done && (!full || pop);

  assign o_data     = mem[rd_ptr_q];
  assign o_count    = count_q;
  assign o_overflow = overflow_q;
  assign o_drop     = drop_q;

  always_comb begin
    idx_d      = idx_q;
    part_d     = part_q;
    timer_d    = timer_q;
    drop_d     = 1'b0;
    overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    // Byte assembly; an arriving byte always wins over the idle timeout.
    if (i_en) begin
      timer_d = '0;
      idx_d   = idx_q + 2'd1;  // 3 wraps back to 0 as the word completes
      case (idx_q)
        2'd0:    part_d[7:0]   = i_data;
        2'd1:    part_d[15:8]  = i_data;
        2'd2:    part_d[23:16] = i_data;
        default: ;
      endcase
    end else if ((idx_q != 2'd0) && (TIMEOUT != 0)) begin
      if (timer_q == T_LAST) begin
        idx_d   = 2'd0;
        timer_d = '0;
        drop_d  = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (word_done && !push) begin
      overflow_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_q      <= 2'd0;
      part_q     <= '0;
      timer_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      part_q     <= part_d;
      timer_q    <= timer_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Word storage is deliberately not reset; only the pointers and count are.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {i_data, part_q};
    end
  end

endmodule

// File: tb/tb_uart_word_rx.sv
// Testbench for uart_word_rx: directed scenarios with literal expectations
// plus a randomized phase, all checked each cycle against a word-level model.
module tb_uart_word_rx;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 20;
  localparam int CW      = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clk     = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [7:0]    i_data  = 8'h00;
  logic          i_en    = 1'b0;
  logic          i_ready = 1'b0;
  logic [31:0]   o_data;
  logic          o_valid;
  logic [CW-1:0] o_count;
  logic          o_overflow;
  logic          o_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_word_rx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_data     (i_data),
    .i_en       (i_en),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_drop     (o_drop)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  // Word-level view: a queue of stored words, the bytes of the word being
  // assembled, and the cycle number of the last accepted byte.
  logic [31:0] exp_q[$];
  logic [7:0]  m_bytes [4];
  int          m_idx;
  int          m_last;
  int          m_cyc;
  bit          m_ovf;
  bit          m_drop;
  bit          m_pop;
  bit          m_done;
  logic [31:0] m_word;

  function automatic void model_reset();
    exp_q.delete();
    m_idx  = 0;
    m_ovf  = 1'b0;
    m_drop = 1'b0;
  endfunction

  initial begin
    model_reset();
    m_cyc  = 0;
    m_last = 0;
    forever begin
      @(posedge clk);
      m_cyc++;
      if (!i_rst_n) begin
        model_reset();
      end else begin
        m_pop  = (exp_q.size() != 0) && i_ready;
        m_done = 1'b0;
        m_drop = 1'b0;
        m_word = '0;
        if (i_en) begin
          m_bytes[m_idx] = i_data;
          m_last = m_cyc;
          if (m_idx == 3) begin
            m_word = {i_data, m_bytes[2], m_bytes[1], m_bytes[0]};
            m_done = 1'b1;
            m_idx  = 0;
          end else begin
            m_idx++;
          end
        end else if (m_idx != 0 && TIMEOUT != 0 && (m_cyc - m_last) == TIMEOUT) begin
          m_idx  = 0;
          m_drop = 1'b1;
        end
        if (m_pop) void'(exp_q.pop_front());
        if (m_done) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(m_word);
          else m_ovf = 1'b1;
        end
        #1;
        if (i_rst_n) begin
          check("o_valid", 32'(o_valid), 32'(exp_q.size() != 0));
          check("o_count", 32'(o_count), 32'(exp_q.size()));
          check("o_overflow", 32'(o_overflow), 32'(m_ovf));
          check("o_drop", 32'(o_drop), 32'(m_drop));
          if (exp_q.size() != 0) check("o_data", o_data, exp_q[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic en, input logic [7:0] d, input logic rdy);
    @(negedge clk);
    i_en    = en;
    i_data  = d;
    i_ready = rdy;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_en    = 1'b0;
    i_ready = 1'b0;
    i_rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] w, input logic rdy_last);
    cyc(1'b1, w[7:0],   1'b0);
    cyc(1'b1, w[15:8],  1'b0);
    cyc(1'b1, w[23:16], 1'b0);
    cyc(1'b1, w[31:24], rdy_last);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          seen;
    int          delay;
    int          bias;
    int          gap;
    logic        rdy;
    logic [31:0] exp_w;

    do_reset();
    #1;
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_count", 32'(o_count), 32'd0);
    check("reset_overflow", 32'(o_overflow), 32'd0);
    check("reset_drop", 32'(o_drop), 32'd0);

    // Single word with the consumer ready.
    cyc(1'b1, 8'h11, 1'b1);
    cyc(1'b1, 8'h22, 1'b1);
    cyc(1'b1, 8'h33, 1'b1);
    cyc(1'b1, 8'h44, 1'b1);
    after_edge();
    check("w1_valid", 32'(o_valid), 32'd1);
    check("w1_data", o_data, 32'h44332211);
    check("w1_count", 32'(o_count), 32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    after_edge();
    check("w1_valid_fall", 32'(o_valid), 32'd0);
    check("w1_count_zero", 32'(o_count), 32'd0);

    // Fill past full, then drain in order.
    do_reset();
    for (int n = 0; n < 17; n++) push_word({4{n[7:0]}}, 1'b0);
    after_edge();
    check("full_count", 32'(o_count), 32'd16);
    check("full_overflow", 32'(o_overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      #1;
      check("drain_order", o_data, {4{i[7:0]}});
    end
    cyc(1'b0, 8'h00, 1'b0);
    #1;
    check("drain_empty", 32'(o_valid), 32'd0);

    // Full FIFO with simultaneous pop and push.
    do_reset();
    for (int n = 0; n < 16; n++) push_word({4{n[7:0]}}, 1'b0);
    push_word(32'hA5C30F99, 1'b1);
    after_edge();
    check("pushpop_count", 32'(o_count), 32'd16);
    check("pushpop_overflow", 32'(o_overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      #1;
      exp_w = (i < 15) ? {4{8'(i + 1)}} : 32'hA5C30F99;
      check("pushpop_order", o_data, exp_w);
    end
    cyc(1'b0, 8'h00, 1'b0);

    // Partial word timeout.
    do_reset();
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    after_edge();
    seen  = 0;
    delay = 0;
    for (int k = 1; k <= TIMEOUT + 5 && seen == 0; k++) begin
      cyc(1'b0, 8'h00, 1'b0);
      after_edge();
      if (o_drop) begin
        seen  = 1;
        delay = k;
      end
    end
    check("drop_seen", 32'(seen), 32'd1);
    check("drop_delay", 32'(delay), 32'(TIMEOUT));
    cyc(1'b0, 8'h00, 1'b0);
    after_edge();
    check("drop_one_cycle", 32'(o_drop), 32'd0);
    push_word(32'hDDCCBBAA, 1'b0);
    after_edge();
    check("after_drop_data", o_data, 32'hDDCCBBAA);
    check("after_drop_count", 32'(o_count), 32'd1);

    // Byte arriving on the would-be timeout edge wins.
    do_reset();
    cyc(1'b1, 8'h5A, 1'b0);
    cyc(1'b1, 8'h6B, 1'b0);
    repeat (TIMEOUT - 1) cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'h7C, 1'b0);
    after_edge();
    check("prec_no_drop", 32'(o_drop), 32'd0);
    cyc(1'b1, 8'h8D, 1'b0);
    after_edge();
    check("prec_data", o_data, 32'h8D7C6B5A);
    check("prec_count", 32'(o_count), 32'd1);

    // Asynchronous reset in the middle of a word.
    do_reset();
    push_word(32'h11223344, 1'b0);
    cyc(1'b1, 8'hF1, 1'b0);
    cyc(1'b1, 8'hF2, 1'b0);
    cyc(1'b1, 8'hF3, 1'b0);
    after_edge();
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    i_rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_valid", 32'(o_valid), 32'd0);
    check("async_rst_count", 32'(o_count), 32'd0);
    check("async_rst_drop", 32'(o_drop), 32'd0);
    check("async_rst_overflow", 32'(o_overflow), 32'd0);
    #1;
    i_rst_n = 1'b1;
    push_word(32'hE4E3E2E1, 1'b0);
    after_edge();
    check("post_rst_data", o_data, 32'hE4E3E2E1);
    check("post_rst_count", 32'(o_count), 32'd1);
    cyc(1'b0, 8'h00, 1'b0);
    after_edge();
    check("post_rst_one_word", 32'(o_count), 32'd1);

    // Randomized traffic with varying consumer bias and idle gaps.
    do_reset();
    bias = 50;
    for (int it = 0; it < 3000; it++) begin
      if (it % 300 == 0) begin
        case ($urandom_range(0, 2))
          0:       bias = 10;
          1:       bias = 50;
          default: bias = 90;
        endcase
      end
      rdy = ($urandom_range(0, 99) < bias);
      if ($urandom_range(0, 19) == 0) begin
        gap = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
        for (int g = 0; g < gap; g++) cyc(1'b0, 8'h00, rdy);
      end else begin
        cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), rdy);
      end
    end
    cyc(1'b0, 8'h00, 1'b0);
    after_edge();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
